hsv2rgb_stream: RTL and testbench

Parametrised HSV-to-RGB colour converter with valid/ready flow control, a configurable channel width, a selectable output channel order (RGB/GRB/BRG), and a sideband tag carried alongside each pixel.
It sits between the effect/pattern generators and the WS2812 serialiser, so it can be stalled by the LED shifter without dropping pixels.
Its fixed 6-cycle pipeline uses a constant divide-by-60 instead of a generic iterative divider.

---
 rtl/hsv_pkg.sv | 46 ++++
 rtl/hsv_div60.sv | 41 ++++
 rtl/hsv2rgb_stream.sv | 178 +++++++++++++++++
 tb/tb_hsv2rgb_stream.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_pkg.sv
// rtl/hsv_pkg.sv - shared constants, channel order codes and sector selection for the HSV converter
package hsv_pkg;

    localparam int HUE_RANGE = 360;
    localparam int SECTOR    = 60;

    localparam int ORD_RGB = 0;
    localparam int ORD_GRB = 1;
    localparam int ORD_BRG = 2;

    // Which intermediate value drives a colour channel.
    typedef enum logic [1:0] {
        SEL_V = 2'd0,
        SEL_P = 2'd1,
        SEL_Q = 2'd2,
        SEL_T = 2'd3
    } chan_sel_e;

    typedef struct packed {
        chan_sel_e r;
        chan_sel_e g;
        chan_sel_e b;
    } sector_sel_t;

    // Hue sector (0..5) to the value feeding each of R, G and B.
    function automatic sector_sel_t sector_sel(input logic [2:0] hi);
        sector_sel_t s;
        case (hi)
            3'd0:    s = '{r: SEL_V, g: SEL_T, b: SEL_P};
            3'd1:    s = '{r: SEL_Q, g: SEL_V, b: SEL_P};
            3'd2:    s = '{r: SEL_P, g: SEL_V, b: SEL_T};
            3'd3:    s = '{r: SEL_P, g: SEL_Q, b: SEL_V};
            3'd4:    s = '{r: SEL_T, g: SEL_P, b: SEL_V};
            default: s = '{r: SEL_V, g: SEL_P, b: SEL_Q};
        endcase
        return s;
    endfunction

    // ceil(2^shift / 60): with shift = input width + 6 the error term
    // (at most 59) times any input stays below 2^shift, so the
    // multiply-and-shift quotient equals floor(x/60) exactly.
    function automatic logic [63:0] div60_recip(input int unsigned shift);
        return ((64'd1 << shift) + 64'(SECTOR - 1)) / 64'(SECTOR);
    endfunction

endpackage

// File: rtl/hsv_div60.sv
// rtl/hsv_div60.sv - one-stage exact floor(x/60) by reciprocal multiply, stalls with the parent pipeline
module hsv_div60
    import hsv_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            adv_i,
    input  logic [CW+5:0]   x_i,
    output logic [CW-1:0]   q_o
);

    // x <= (2^CW-1)*59 < 2^(CW+6); reciprocal fits in SH-5 bits.
    localparam int XW = CW + 6;
    localparam int SH = XW + 6;
    localparam int MW = SH - 5;
    localparam logic [63:0]   RECIP_FULL = div60_recip(SH);
    localparam logic [MW-1:0] RECIP      = RECIP_FULL[MW-1:0];

    logic [XW+MW-1:0] prod;
    logic [CW-1:0]    q_d;
    logic [CW-1:0]    q_q;
    logic             div_unused;

    assign prod       = {{MW{1'b0}}, x_i} * {{XW{1'b0}}, RECIP};
    assign q_d        = prod[SH +: CW];
    assign div_unused = ^{prod[SH-1:0], prod[XW+MW-1:SH+CW]};

    // Quotient register, frozen together with the rest of the pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else if (adv_i) begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/hsv2rgb_stream.sv
// rtl/hsv2rgb_stream.sv - six-stage HSV to RGB converter with valid/ready stall and tag sideband
module hsv2rgb_stream
    import hsv_pkg::*;
#(
    parameter int CW    = 8,
    parameter int TAG_W = 8,
    parameter int ORDER = 0
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             hsv_valid,
    output logic             hsv_ready,
    input  logic [8:0]       Hue,
    input  logic [CW-1:0]    Saturation,
    input  logic [CW-1:0]    Value,
    input  logic [TAG_W-1:0] tag_in,
    output logic             rgb_valid,
    input  logic             rgb_ready,
    output logic [CW-1:0]    c0,
    output logic [CW-1:0]    c1,
    output logic [CW-1:0]    c2,
    output logic [TAG_W-1:0] tag_out
);

    // Stage valid bits: bit 0 is S1, bit 5 is the output stage.
    logic [5:0] vld_q;
    logic       adv;

    // S1: folded hue and raw S/V.
    logic [8:0]       h1_d, h1_q;
    logic [CW-1:0]    s1_q, v1_q;
    logic [TAG_W-1:0] tag1_q;
    // S2: sector, offset and V*S.
    logic [2:0]       hi2_d, hi2_q;
    logic [5:0]       f2_d, f2_q;
    logic [8:0]       base2, rem2;
    logic [2*CW-1:0]  vs_prod;
    logic [CW-1:0]    vs2_d, vs2_q, v2_q;
    logic [TAG_W-1:0] tag2_q;
    // S3: VS*f numerator.
    logic [CW+5:0]    num3_d, num3_q;
    logic [2:0]       hi3_q;
    logic [CW-1:0]    vs3_q, v3_q;
    logic [TAG_W-1:0] tag3_q;
    // S4: VSF from the divider, the rest carried alongside.
    logic [CW-1:0]    vsf4_q;
    logic [2:0]       hi4_q;
    logic [CW-1:0]    vs4_q, v4_q;
    logic [TAG_W-1:0] tag4_q;
    // S5: p, q, t.
    logic [CW-1:0]    p5_d, q5_d, t5_d;
    logic [CW-1:0]    p5_q, q5_q, t5_q, v5_q;
    logic [2:0]       hi5_q;
    logic [TAG_W-1:0] tag5_q;
    // S6: output channels.
    sector_sel_t      sel6;
    logic [CW-1:0]    r6, g6, b6;
    logic [CW-1:0]    c0_d, c1_d, c2_d;
    logic [CW-1:0]    c0_q, c1_q, c2_q;
    logic [TAG_W-1:0] tag6_q;
    logic             stage_unused;

    function automatic logic [CW-1:0] pick(input chan_sel_e sel, input logic [CW-1:0] v,
                                           input logic [CW-1:0] p, input logic [CW-1:0] q,
                                           input logic [CW-1:0] t);
        case (sel)
            SEL_V:   return v;
            SEL_P:   return p;
            SEL_Q:   return q;
            default: return t;
        endcase
    endfunction

    // The whole pipeline moves as one unless the output pixel is blocked.
    assign adv       = !vld_q[5] || rgb_ready;
    assign hsv_ready = adv;

    assign h1_d = (Hue >= 9'(HUE_RANGE)) ? Hue - 9'(HUE_RANGE) : Hue;

    // S2 combinational: sector by threshold compare, V*S scaled back to CW bits.
    always_comb begin
        hi2_d = 3'd0;
        base2 = 9'd0;
        for (int k = 1; k < 6; k++) begin
            if (h1_q >= 9'(k * SECTOR)) begin
                hi2_d = 3'(k);
                base2 = 9'(k * SECTOR);
            end
        end
        rem2    = h1_q - base2;
        f2_d    = rem2[5:0];
        vs_prod = {{CW{1'b0}}, v1_q} * {{CW{1'b0}}, s1_q};
        vs2_d   = vs_prod[2*CW-1:CW];
    end

    assign num3_d = {6'd0, vs3_q_src()} * {{CW{1'b0}}, f2_q};

    function automatic logic [CW-1:0] vs3_q_src();
        return vs2_q;
    endfunction

    hsv_div60 #(.CW(CW)) u_div60 (
        .clk_i (sys_clk),
        .rst_i (rst),
        .adv_i (adv),
        .x_i   (num3_q),
        .q_o   (vsf4_q)
    );

    assign p5_d = v4_q - vs4_q;
    assign q5_d = v4_q - vsf4_q;
    assign t5_d = v4_q - vs4_q + vsf4_q;

    // S6 combinational: sector routing then the fixed channel order.
    always_comb begin
        sel6 = sector_sel(hi5_q);
        r6   = pick(sel6.r, v5_q, p5_q, q5_q, t5_q);
        g6   = pick(sel6.g, v5_q, p5_q, q5_q, t5_q);
        b6   = pick(sel6.b, v5_q, p5_q, q5_q, t5_q);
        c0_d = r6;
        c1_d = g6;
        c2_d = b6;
        case (ORDER)
            ORD_GRB: begin
                c0_d = g6;
                c1_d = r6;
                c2_d = b6;
            end
            ORD_BRG: begin
                c0_d = b6;
                c1_d = r6;
                c2_d = g6;
            end
            default: begin
                c0_d = r6;
                c1_d = g6;
                c2_d = b6;
            end
        endcase
    end

    assign stage_unused = ^{rem2[8:6], vs_prod[CW-1:0]};

    // Valid bits shift in lockstep with the data; reset drops every in-flight pixel.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= {vld_q[4:0], hsv_valid};
        end
    end

    // Data and tag stage registers; bubbles are simply overwritten later.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            h1_q   <= '0; s1_q  <= '0; v1_q  <= '0; tag1_q <= '0;
            hi2_q  <= '0; f2_q  <= '0; vs2_q <= '0; v2_q   <= '0; tag2_q <= '0;
            num3_q <= '0; hi3_q <= '0; vs3_q <= '0; v3_q   <= '0; tag3_q <= '0;
            hi4_q  <= '0; vs4_q <= '0; v4_q  <= '0; tag4_q <= '0;
            p5_q   <= '0; q5_q  <= '0; t5_q  <= '0; v5_q   <= '0; hi5_q  <= '0; tag5_q <= '0;
            c0_q   <= '0; c1_q  <= '0; c2_q  <= '0; tag6_q <= '0;
        end else if (adv) begin
            h1_q   <= h1_d;   s1_q  <= Saturation; v1_q  <= Value; tag1_q <= tag_in;
            hi2_q  <= hi2_d;  f2_q  <= f2_d;   vs2_q <= vs2_d; v2_q   <= v1_q;  tag2_q <= tag1_q;
            num3_q <= num3_d; hi3_q <= hi2_q;  vs3_q <= vs2_q; v3_q   <= v2_q;  tag3_q <= tag2_q;
            hi4_q  <= hi3_q;  vs4_q <= vs3_q;  v4_q  <= v3_q;  tag4_q <= tag3_q;
            p5_q   <= p5_d;   q5_q  <= q5_d;   t5_q  <= t5_d;  v5_q   <= v4_q;  hi5_q  <= hi4_q; tag5_q <= tag4_q;
            c0_q   <= c0_d;   c1_q  <= c1_d;   c2_q  <= c2_d;  tag6_q <= tag5_q;
        end
    end

    assign rgb_valid = vld_q[5];
    assign c0        = c0_q;
    assign c1        = c1_q;
    assign c2        = c2_q;
    assign tag_out   = tag6_q;

endmodule

// File: tb/tb_hsv2rgb_stream.sv
// tb/tb_hsv2rgb_stream.sv - randomized self-checking bench for hsv2rgb_stream in all three channel orders
module tb_hsv2rgb_stream;

    localparam int CW    = 8;
    localparam int TAG_W = 8;

    logic                      sys_clk = 1'b0;
    logic                      rst;
    logic                      hsv_valid;
    logic [8:0]                Hue;
    logic [CW-1:0]             Saturation;
    logic [CW-1:0]             Value;
    logic [TAG_W-1:0]          tag_in;
    logic                      rgb_ready;
    logic [2:0]                hsv_ready_w;
    logic [2:0]                rgb_valid_w;
    logic [2:0][CW-1:0]        c0_w, c1_w, c2_w;
    logic [2:0][TAG_W-1:0]     tag_out_w;

    int n_cmp = 0;
    int n_bad = 0;
    int n_in  = 0;
    int n_out = 0;

    // Expected pipeline occupancy: six slots of {tag, R, G, B}.
    logic        m_vld [6];
    logic [31:0] m_dat [6];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hsv2rgb_stream #(.CW(CW), .TAG_W(TAG_W), .ORDER(g)) u_dut (
            .sys_clk    (sys_clk),
            .rst        (rst),
            .hsv_valid  (hsv_valid),
            .hsv_ready  (hsv_ready_w[g]),
            .Hue        (Hue),
            .Saturation (Saturation),
            .Value      (Value),
            .tag_in     (tag_in),
            .rgb_valid  (rgb_valid_w[g]),
            .rgb_ready  (rgb_ready),
            .c0         (c0_w[g]),
            .c1         (c1_w[g]),
            .c2         (c2_w[g]),
            .tag_out    (tag_out_w[g])
        );
    end

    always #5 sys_clk = ~sys_clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    // Colour reference straight from the HSV formulas, returns {R,G,B}.
    function automatic logic [23:0] ref_rgb(input int h, input int s, input int v);
        int hh, sec, f, vs, vsf, p, q, t, r, g, b;
        hh  = (h >= 360) ? h - 360 : h;
        sec = hh / 60;
        f   = hh % 60;
        vs  = (v * s) / 256;
        vsf = (vs * f) / 60;
        p   = v - vs;
        q   = v - vsf;
        t   = v - vs + vsf;
        case (sec)
            0:       begin r = v; g = t; b = p; end
            1:       begin r = q; g = v; b = p; end
            2:       begin r = p; g = v; b = t; end
            3:       begin r = p; g = q; b = v; end
            4:       begin r = t; g = p; b = v; end
            default: begin r = v; g = p; b = q; end
        endcase
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    // Rearrange {tag,R,G,B} into {tag,c0,c1,c2} for a given channel order.
    function automatic logic [31:0] ordered(input int ord, input logic [31:0] e);
        logic [7:0] tg, r, g, b;
        tg = e[31:24];
        r  = e[23:16];
        g  = e[15:8];
        b  = e[7:0];
        case (ord)
            1:       return {tg, g, r, b};
            2:       return {tg, b, r, g};
            default: return {tg, r, g, b};
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 6; i++) begin
            m_vld[i] = 1'b0;
            m_dat[i] = '0;
        end
    endtask

    // Drive one cycle, check every DUT against the model, then clock.
    task automatic clock_cycle(input bit vld, input int h, input int s, input int v, input int tg,
                               input bit rdy, input bit use_ovr, input logic [23:0] ovr,
                               output bit acc);
        bit          adv;
        logic [31:0] exp;
        hsv_valid  = vld;
        Hue        = 9'(h);
        Saturation = 8'(s);
        Value      = 8'(v);
        tag_in     = 8'(tg);
        rgb_ready  = rdy;
        exp = {8'(tg), (use_ovr ? ovr : ref_rgb(h, s, v))};
        #1;
        adv = !m_vld[5] || rdy;
        for (int g = 0; g < 3; g++) begin
            expect_eq($sformatf("hsv_ready%0d", g), 32'(hsv_ready_w[g]), 32'(adv));
            expect_eq($sformatf("rgb_valid%0d", g), 32'(rgb_valid_w[g]), 32'(m_vld[5]));
            if (m_vld[5])
                expect_eq($sformatf("pixel%0d", g),
                          {tag_out_w[g], c0_w[g], c1_w[g], c2_w[g]}, ordered(g, m_dat[5]));
        end
        if (m_vld[5] && rdy) n_out++;
        acc = vld && adv;
        if (acc) n_in++;
        if (adv) begin
            for (int i = 5; i > 0; i--) begin
                m_vld[i] = m_vld[i-1];
                m_dat[i] = m_dat[i-1];
            end
            m_vld[0] = vld;
            m_dat[0] = exp;
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) clock_cycle(1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 24'd0, acc);
    endtask

    initial begin
        bit acc;
        int tries;
        int lat;
        int tag_ctr;
        int sv_set [4];
        sv_set[0] = 0; sv_set[1] = 1; sv_set[2] = 128; sv_set[3] = 255;
        tag_ctr = 1;

        rst = 1'b1; hsv_valid = 1'b0; Hue = '0; Saturation = '0; Value = '0;
        tag_in = '0; rgb_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge sys_clk);
        #1;
        rst = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            expect_eq($sformatf("reset_valid%0d", g), 32'(rgb_valid_w[g]), 32'd0);
            expect_eq($sformatf("reset_data%0d", g), {tag_out_w[g], c0_w[g], c1_w[g], c2_w[g]}, 32'd0);
            expect_eq($sformatf("reset_ready%0d", g), 32'(hsv_ready_w[g]), 32'd1);
        end

        // Directed pixels with hand-derived colours where known.
        clock_cycle(1'b1,   0, 255, 255, 8'h11, 1'b1, 1'b0, 24'd0, acc);
        clock_cycle(1'b1, 120, 255, 255, 8'h12, 1'b1, 1'b0, 24'd0, acc);
        clock_cycle(1'b1, 240, 255, 255, 8'h13, 1'b1, 1'b0, 24'd0, acc);
        clock_cycle(1'b1,  30, 255, 255, 8'h5A, 1'b1, 1'b1, {8'd255, 8'd128, 8'd1}, acc);
        clock_cycle(1'b1, 400, 255, 255, 8'h14, 1'b1, 1'b1, {8'd255, 8'd170, 8'd1}, acc);
        clock_cycle(1'b1,  40, 255, 255, 8'h15, 1'b1, 1'b1, {8'd255, 8'd170, 8'd1}, acc);
        clock_cycle(1'b1,   0,   0, 100, 8'h16, 1'b1, 1'b1, {8'd100, 8'd100, 8'd100}, acc);
        clock_cycle(1'b1,  59,   0, 100, 8'h17, 1'b1, 1'b1, {8'd100, 8'd100, 8'd100}, acc);
        clock_cycle(1'b1, 359,   0, 100, 8'h18, 1'b1, 1'b1, {8'd100, 8'd100, 8'd100}, acc);
        clock_cycle(1'b1, 200,  77,   0, 8'h19, 1'b1, 1'b1, 24'd0, acc);
        clock_cycle(1'b1, 511, 255,   0, 8'h1A, 1'b1, 1'b1, 24'd0, acc);
        idle(8);

        // Exhaustive hue sweep with random bubbles and random downstream stalls.
        for (int si = 0; si < 4; si++) begin
            for (int vi = 0; vi < 4; vi++) begin
                for (int h = 0; h < 360; h++) begin
                    tries = 0;
                    acc   = 1'b0;
                    while (!acc && tries < 200) begin
                        if ($urandom_range(0, 4) == 0)
                            clock_cycle(1'b0, 0, 0, 0, 0, ($urandom_range(0, 9) < 7), 1'b0, 24'd0, acc);
                        clock_cycle(1'b1, h, sv_set[si], sv_set[vi], tag_ctr,
                                    ($urandom_range(0, 9) < 7), 1'b0, 24'd0, acc);
                        tries++;
                    end
                    expect_eq("accept_bound", 32'(acc), 32'd1);
                    tag_ctr = (tag_ctr + 1) % 256;
                end
            end
        end
        // Random out-of-range hues exercise the fold.
        for (int i = 0; i < 40; i++) begin
            clock_cycle(1'b1, $urandom_range(360, 511), $urandom_range(0, 255), $urandom_range(0, 255),
                        i, ($urandom_range(0, 1) == 1), 1'b0, 24'd0, acc);
        end
        idle(10);
        expect_eq("no_loss", 32'(n_out), 32'(n_in));

        // Reset with four pixels in flight: none of them may emerge.
        for (int i = 0; i < 4; i++)
            clock_cycle(1'b1, 60 * i, 200, 150, 8'hC0 + i, 1'b1, 1'b0, 24'd0, acc);
        rst = 1'b1;
        hsv_valid = 1'b0;
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        model_clear();
        idle(8);

        // Latency of the first pixel after reset, counted in clock edges from acceptance.
        clock_cycle(1'b1, 75, 180, 220, 8'hEE, 1'b1, 1'b0, 24'd0, acc);
        lat = 1;
        while (!rgb_valid_w[0] && lat < 20) begin
            clock_cycle(1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 24'd0, acc);
            lat++;
        end
        expect_eq("latency", 32'(lat), 32'd6);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
